// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory responder: FSM state encoding,
// default parameter values, access-type encoding and an alignment helper.
// Optional feature macro: DMEM_ERR_CHECK_EN (adds the err response flag).
package dmem_pkg;

    localparam int DEFAULT_DEPTH_WORDS = 1024;
    localparam int DEFAULT_WAIT_CYCLES = 1;

    // Encoding of the we_re request field
    localparam logic WE_WRITE = 1'b1;
    localparam logic WE_READ  = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // A halfword access must sit on an even byte address and a word access
    // on a word boundary; single-byte and irregular masks are never flagged.
    function automatic logic dmem_misaligned(input logic [3:0] mask,
                                             input logic [1:0] addr_lo);
        logic is_half;
        logic is_word;
        is_half = (mask == 4'b0011) || (mask == 4'b1100);
        is_word = (mask == 4'b1111);
        return (is_half && addr_lo[0]) || (is_word && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Core <-> data memory bus. The core side is the master (issues request),
// the memory responder is the slave (returns valid/load_data).
// Optional feature macro: DMEM_ERR_CHECK_EN (adds the err signal).
interface data_mem_responder_if;

    logic        request;
    logic        we_re;
    logic [3:0]  mask;
    logic [31:0] address;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic        valid;
`ifdef DMEM_ERR_CHECK_EN
    logic        err;
`endif

`ifdef DMEM_ERR_CHECK_EN
    modport master (
        output request, we_re, mask, address, store_data,
        input  load_data, valid, err
    );

    modport slave (
        input  request, we_re, mask, address, store_data,
        output load_data, valid, err
    );
`else
    modport master (
        output request, we_re, mask, address, store_data,
        input  load_data, valid
    );

    modport slave (
        input  request, we_re, mask, address, store_data,
        output load_data, valid
    );
`endif

endinterface

// File: rtl/dmem_sram_array.sv
// Single-port word memory built from four byte-wide lanes so that each lane
// has its own write enable. Read data is registered and only reloads on a
// read access, so it holds across writes and idle cycles. Contents are
// never reset; only the read register is.
module dmem_sram_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en_i,
    input  logic                           we_i,
    input  logic [3:0]                     be_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
    input  logic [31:0]                    wdata_i,
    input  logic                           clr_i,
    output logic [31:0]                    rdata_o
);

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem_q [DEPTH_WORDS];
        logic [7:0] rbyte_q;

        // Byte-lane write: only lanes whose enable is set are touched
        always_ff @(posedge clk) begin
            if (en_i && we_i && be_i[gi]) begin
                lane_mem_q[addr_i] <= wdata_i[8*gi +: 8];
            end
        end

        // Registered read; clr_i substitutes zero for a rejected read
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rbyte_q <= 8'h00;
            end else if (en_i && !we_i) begin
                rbyte_q <= clr_i ? 8'h00 : lane_mem_q[addr_i];
            end
        end

        assign rdata_o[8*gi +: 8] = rbyte_q;
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: accepts one load/store at a time from the core,
// inserts WAIT_CYCLES wait states, performs the access on the edge that
// enters RESP and raises valid for exactly one cycle.
// Optional feature macro: DMEM_ERR_CHECK_EN -- flags out-of-range and
// misaligned accesses via err, suppressing their memory side effects.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    data_mem_responder_if.slave bus
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    dmem_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] wdata_q, wdata_d;
    logic        go_resp;

    // Operands of the access being performed this edge
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic        op_we;
    logic [3:0]  op_mask;
    logic        op_err;

    logic [3:0]  sram_be;
    logic        sram_we;
    logic [31:0] sram_rdata;

    // Next-state logic: capture on accept, count wait states, one RESP cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        mask_d  = mask_q;
        wdata_d = wdata_q;
        go_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.request) begin
                    addr_d  = bus.address;
                    we_d    = bus.we_re;
                    mask_d  = bus.mask;
                    wdata_d = bus.store_data;
                    cnt_d   = WAIT_INIT;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    go_resp = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and captured operand registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            we_q    <= 1'b0;
            mask_q  <= 4'h0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            mask_q  <= mask_d;
            wdata_q <= wdata_d;
        end
    end

    // With zero wait states the access happens on the accept edge itself,
    // before the captured registers are loaded, so take the live bus then.
    always_comb begin
        op_addr  = addr_q;
        op_wdata = wdata_q;
        op_we    = we_q;
        op_mask  = mask_q;
        if (state_q == IDLE) begin
            op_addr  = bus.address;
            op_wdata = bus.store_data;
            op_we    = bus.we_re;
            op_mask  = bus.mask;
        end
    end

`ifdef DMEM_ERR_CHECK_EN
    logic err_q, err_d;

    // Any address bit above the word index means the access is out of range
    assign op_err = (op_addr[31:IDX_W+2] != '0) ||
                    dmem_misaligned(op_mask, op_addr[1:0]);

    // Latch the error verdict alongside the access it belongs to
    always_comb begin
        err_d = err_q;
        if (go_resp) begin
            err_d = op_err;
        end
    end

    // Error flag register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q && (state_q == RESP);
`else
    // Upper address bits and the byte offset simply wrap / are dropped
    logic unused_addr_bits;
    assign unused_addr_bits = ^{op_addr[31:IDX_W+2], op_addr[1:0]};
    assign op_err = 1'b0;
`endif

    // Rejected writes get no lane enables; rejected reads return zero
    always_comb begin
        sram_we = (op_we == WE_WRITE);
        sram_be = 4'b0000;
        if (go_resp && sram_we && !op_err) begin
            sram_be = op_mask;
        end
    end

    dmem_sram_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_sram (
        .clk     (clk),
        .rst_n   (rst),
        .en_i    (go_resp),
        .we_i    (sram_we),
        .be_i    (sram_be),
        .addr_i  (op_addr[IDX_W+1:2]),
        .wdata_i (op_wdata),
        .clr_i   (op_err),
        .rdata_o (sram_rdata)
    );

    assign bus.load_data = sram_rdata;
    assign bus.valid     = (state_q == RESP);

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder. Three instances with
// WAIT_CYCLES = 1, 0, 3 share clock and reset. Stimulus pushes the
// expected response (data, err, cycle of valid) into a queue; a monitor
// pops and compares whenever an instance raises valid.
// Honours DMEM_ERR_CHECK_EN to select the error-checking expectations.
module tb_data_mem_responder;

    logic clk;
    logic rst_n;

    logic        req_s   [3];
    logic        we_s    [3];
    logic [3:0]  mask_s  [3];
    logic [31:0] addr_s  [3];
    logic [31:0] wdata_s [3];
    logic [31:0] ld_s    [3];
    logic        vld_s   [3];
`ifdef DMEM_ERR_CHECK_EN
    logic        err_s   [3];
`endif
    logic        vld_prev [3];
    logic [31:0] last_rd  [3];

    typedef struct {
        int          k;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int cyc;
    int checks;
    int errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int W = (gi == 0) ? 1 : ((gi == 1) ? 0 : 3);
        data_mem_responder_if bus();

        assign bus.request    = req_s[gi];
        assign bus.we_re      = we_s[gi];
        assign bus.mask       = mask_s[gi];
        assign bus.address    = addr_s[gi];
        assign bus.store_data = wdata_s[gi];
        assign ld_s[gi]       = bus.load_data;
        assign vld_s[gi]      = bus.valid;
`ifdef DMEM_ERR_CHECK_EN
        assign err_s[gi]      = bus.err;
`endif

        data_mem_responder #(
            .DEPTH_WORDS (1024),
            .WAIT_CYCLES (W)
        ) u_dut (
            .clk (clk),
            .rst (rst_n),
            .bus (bus)
        );
    end

    function automatic int wait_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    // Monitor: every valid pulse must match the oldest expectation
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (vld_s[k]) begin
                checks++;
                if (vld_prev[k]) begin
                    errors++;
                    $display("FAIL valid_pulse dut%0d: valid high on consecutive cycles at cycle %0d, required single-cycle pulse", k, cyc);
                end
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid dut%0d: valid at cycle %0d, required no response", k, cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    checks++;
                    if (mon_e.k != k) begin
                        errors++;
                        $display("FAIL resp_source: valid from dut%0d, required dut%0d", k, mon_e.k);
                    end
                    checks++;
                    if (cyc != mon_e.cyc) begin
                        errors++;
                        $display("FAIL latency dut%0d: valid at cycle %0d, required cycle %0d", k, cyc, mon_e.cyc);
                    end
                    checks++;
                    if (ld_s[k] !== mon_e.data) begin
                        errors++;
                        $display("FAIL load_data dut%0d: got 0x%08h, required 0x%08h", k, ld_s[k], mon_e.data);
                    end
`ifdef DMEM_ERR_CHECK_EN
                    checks++;
                    if (err_s[k] !== mon_e.err) begin
                        errors++;
                        $display("FAIL err dut%0d: got %0b, required %0b", k, err_s[k], mon_e.err);
                    end
`endif
                end
            end
            vld_prev[k] = vld_s[k];
        end
    end

    // Issue one access (or n back-to-back repeats with request held high).
    // For single accesses the bus is scrambled right after acceptance to
    // prove the responder works from its captured operands.
    task automatic do_access(input int k, input logic we, input logic [3:0] m,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] rd_exp, input logic e_err,
                             input int n);
        exp_t e;
        int   w;
        int   base;
        int   got;
        w = wait_of(k);
        @(negedge clk);
        we_s[k]    = we;
        mask_s[k]  = m;
        addr_s[k]  = a;
        wdata_s[k] = d;
        req_s[k]   = 1'b1;
        base = cyc + 1 + w;
        for (int i = 0; i < n; i++) begin
            e.k    = k;
            e.err  = e_err;
            e.cyc  = base + i * (w + 2);
            e.data = we ? last_rd[k] : rd_exp;
            sb_q.push_back(e);
        end
        if (!we) last_rd[k] = rd_exp;
        $display("txn dut%0d %s addr=0x%08h mask=%b wdata=0x%08h repeat=%0d expect_data=0x%08h expect_err=%0b",
                 k, we ? "WR" : "RD", a, m, d, n, e.data, e_err);
        got = 0;
        for (int t = 0; t < 20 * n && got < n; t++) begin
            @(negedge clk);
            if (vld_s[k]) begin
                got++;
                if (got == n) req_s[k] = 1'b0;
            end else if (t == 0 && n == 1) begin
                addr_s[k]  = a ^ 32'h40;
                wdata_s[k] = ~d;
            end
        end
        checks++;
        if (got < n) begin
            errors++;
            $display("FAIL timeout dut%0d: %0d valid pulses seen, required %0d", k, got, n);
            req_s[k] = 1'b0;
        end
    endtask

    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_s[k]    = 1'b0;
            we_s[k]     = 1'b0;
            mask_s[k]   = 4'h0;
            addr_s[k]   = 32'h0;
            wdata_s[k]  = 32'h0;
            vld_prev[k] = 1'b0;
            last_rd[k]  = 32'h0;
        end

        // Reset state of every instance
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (vld_s[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_valid dut%0d: got %0b, required 0", k, vld_s[k]);
            end
            checks++;
            if (ld_s[k] !== 32'h0) begin
                errors++;
                $display("FAIL reset_load_data dut%0d: got 0x%08h, required 0x00000000", k, ld_s[k]);
            end
        end

        // First request on the first edge with reset released
        @(posedge clk);
        #1 rst_n = 1'b1;
        do_access(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1);
        do_access(0, 1'b1, 4'hF, 32'h50, 32'h13579BDF, 32'h0, 1'b0, 1);
        do_access(0, 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1);
        // Single byte lane
        do_access(0, 1'b1, 4'b0100, 32'h10, 32'h00AA0000, 32'h0, 1'b0, 1);
        do_access(0, 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEAABEEF, 1'b0, 1);
        // Empty mask leaves memory untouched
        do_access(0, 1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b0, 1);
        do_access(0, 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEAABEEF, 1'b0, 1);
`ifdef DMEM_ERR_CHECK_EN
        do_access(0, 1'b0, 4'hF, 32'h1010, 32'h0, 32'h0, 1'b1, 1);
        do_access(0, 1'b1, 4'hF, 32'h12, 32'h11111111, 32'h0, 1'b1, 1);
        do_access(0, 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEAABEEF, 1'b0, 1);
`else
        do_access(0, 1'b0, 4'hF, 32'h1010, 32'h0, 32'hDEAABEEF, 1'b0, 1);
        do_access(0, 1'b0, 4'hF, 32'h13, 32'h0, 32'hDEAABEEF, 1'b0, 1);
`endif
        // Request held high across RESP is taken again
        do_access(0, 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEAABEEF, 1'b0, 2);
        do_access(0, 1'b0, 4'hF, 32'h50, 32'h0, 32'h13579BDF, 1'b0, 1);

        // Latency sweep on the zero- and three-wait-state instances
        do_access(1, 1'b1, 4'hF, 32'h4, 32'hA5A5A5A5, 32'h0, 1'b0, 1);
        do_access(1, 1'b0, 4'hF, 32'h4, 32'h0, 32'hA5A5A5A5, 1'b0, 1);
        do_access(1, 1'b0, 4'hF, 32'h4, 32'h0, 32'hA5A5A5A5, 1'b0, 2);
        do_access(2, 1'b1, 4'hF, 32'h4, 32'h5A5A5A5A, 32'h0, 1'b0, 1);
        do_access(2, 1'b0, 4'hF, 32'h4, 32'h0, 32'h5A5A5A5A, 1'b0, 1);
        do_access(2, 1'b0, 4'hF, 32'h4, 32'h0, 32'h5A5A5A5A, 1'b0, 2);

        // Reset in WAIT aborts a pending write
        do_access(0, 1'b1, 4'hF, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, 1);
        @(negedge clk);
        we_s[0]    = 1'b1;
        mask_s[0]  = 4'hF;
        addr_s[0]  = 32'h20;
        wdata_s[0] = 32'h12345678;
        req_s[0]   = 1'b1;
        $display("txn dut0 WR addr=0x00000020 mask=1111 wdata=0x12345678 aborted by reset in WAIT");
        @(negedge clk);
        rst_n    = 1'b0;
        req_s[0] = 1'b0;
        for (int k = 0; k < 3; k++) last_rd[k] = 32'h0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ld_s[k] !== 32'h0) begin
                errors++;
                $display("FAIL abort_reset_load_data dut%0d: got 0x%08h, required 0x00000000", k, ld_s[k]);
            end
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        do_access(0, 1'b0, 4'hF, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 1);

        // Nothing left outstanding and no stray responses
        repeat (6) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
